mem_arbiter_ram: RTL and testbench

Parametrised on-chip word memory serving NUM_PORTS requesters on the cpu bus (enable/wstrb/addr/wvalue/rvalue), extended with a per-port ready handshake, configurable wait states, round-robin arbitration, byte-strobed writes and out-of-range error reporting. It replaces the single-port, fixed-one-cycle memory hookup so that separate instruction/data ports, or a CPU plus a debug/DMA master, can share one memory in simulation and on FPGA.

---
 rtl/mem_arbiter_ram.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter_ram.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ram.sv
// mem_arbiter_ram: one word memory shared by NUM_PORTS cpu-bus masters.
// Round-robin grant, optional wait states, byte strobes, range errors.
//
// Ports (port p of NUM_PORTS):
//   clk_i, rst_i      clock, synchronous active-high reset
//   enable_i[p]       request, held with payload until ready_o[p]
//   wstrb_i[4p+:4]    byte write strobes, 0 = read
//   addr_i[32p+:32]   byte address (bits 1:0 ignored)
//   wvalue_i[32p+:32] write data
//   rvalue_o[32p+:32] pre-access word (or ERR_VALUE), only while ready
//   ready_o[p]        one-cycle completion pulse
//   err_o[p]          out-of-range flag, qualified by ready_o[p]
module mem_arbiter_ram #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_VALUE   = 32'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_PORTS-1:0]    enable_i,
  input  logic [4*NUM_PORTS-1:0]  wstrb_i,
  input  logic [32*NUM_PORTS-1:0] addr_i,
  input  logic [32*NUM_PORTS-1:0] wvalue_i,
  output logic [32*NUM_PORTS-1:0] rvalue_o,
  output logic [NUM_PORTS-1:0]    ready_o,
  output logic [NUM_PORTS-1:0]    err_o
);

  localparam int unsigned IW =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [IW:0] NPW = (IW+1)'(NUM_PORTS);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic err_q;

  logic [NUM_PORTS-1:0] gsel;
  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] rot;
  logic found;
  logic [IW-1:0] ofs;
  logic [IW:0] sum;
  logic [IW:0] inc;
  logic [IW-1:0] win;
  logic [IW-1:0] rr_nxt;

  logic acc_en;
  logic [IW-1:0] acc_port;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0] acc_strb;
  logic [32:0] addr_x;
  logic [32:0] off;
  logic in_range;
  logic [AW-1:0] idx;
  logic unused_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign gsel = NUM_PORTS'(1) << g_q;

  // Rotate candidates so rr sits at bit 0; the lowest set bit
  // of the rotated vector is the next port upward from rr.
  always_comb begin
    cand = enable_i;
    if (state_q == S_RESP) begin
      cand = enable_i & ~gsel;
    end
    rot = NUM_PORTS'({cand, cand} >> rr_q);
    found = 1'b0;
    ofs = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        ofs = IW'(j);
      end
    end
    sum = {1'b0, rr_q} + {1'b0, ofs};
    win = (sum >= NPW) ? IW'(sum - NPW) : IW'(sum);
    inc = {1'b0, win} + (IW+1)'(1);
    rr_nxt = (inc >= NPW) ? '0 : IW'(inc);
  end

  always_comb begin
    state_d = state_q;
    g_d = g_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    acc_en = 1'b0;
    acc_port = g_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (found) begin
          g_d = win;
          rr_d = rr_nxt;
          acc_port = win;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            acc_en = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          acc_en = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_addr = '0;
    acc_wdata = '0;
    acc_strb = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (IW'(p) == acc_port) begin
        acc_addr = addr_i[32*p +: 32];
        acc_wdata = wvalue_i[32*p +: 32];
        acc_strb = wstrb_i[4*p +: 4];
      end
    end
  end

  // 33-bit compare so a window ending at 2^32 does not wrap.
  assign addr_x = {1'b0, acc_addr};
  assign in_range = (addr_x >= LO) && (addr_x < HI);
  assign off = addr_x - LO;
  assign idx = off[AW+1:2];
  assign unused_bits = ^{off[32:AW+2], off[1:0]};

  // Reset at the access edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && acc_en && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_strb[b]) begin
          mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      g_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      if (acc_en) begin
        rdata_q <= in_range ? mem[idx] : ERR_VALUE;
        err_q <= !in_range;
      end
    end
  end

  always_comb begin
    ready_o = '0;
    err_o = '0;
    rvalue_o = '0;
    if (state_q == S_RESP) begin
      ready_o = gsel;
      err_o = err_q ? gsel : '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gsel[p]) begin
          rvalue_o[32*p +: 32] = rdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ram.sv
// Bench for mem_arbiter_ram: instance 0 (base 0, no waits) and
// instance 1 (base 0x8000_0000, 3 waits) against a scoreboard.
module tb_mem_arbiter_ram;

  localparam int NP = 2;
  localparam int DW = 1024;
  localparam logic [31:0] BASE1 = 32'h8000_0000;
  localparam logic [31:0] ERR1 = 32'hBAD0_0BAD;

  typedef struct packed {
    logic [31:0] data;
    logic err;
    int cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0] en [2];
  logic [4*NP-1:0] st [2];
  logic [32*NP-1:0] ad [2];
  logic [32*NP-1:0] wv [2];
  logic [32*NP-1:0] rv0, rv1;
  logic [NP-1:0] rdy0, rdy1, er0, er1;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mm [2][DW];
  int rr_m [2];
  sb_t q [2*NP][$];

  mem_arbiter_ram #(
    .NUM_PORTS(NP), .DEPTH_WORDS(DW), .BASE_ADDR(32'h0),
    .WAIT_STATES(0), .ERR_VALUE(32'h0)
  ) u_ram0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .wstrb_i(st[0]),
    .addr_i(ad[0]), .wvalue_i(wv[0]), .rvalue_o(rv0),
    .ready_o(rdy0), .err_o(er0)
  );

  mem_arbiter_ram #(
    .NUM_PORTS(NP), .DEPTH_WORDS(DW), .BASE_ADDR(BASE1),
    .WAIT_STATES(3), .ERR_VALUE(ERR1)
  ) u_ram1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .wstrb_i(st[1]),
    .addr_i(ad[1]), .wvalue_i(wv[1]), .rvalue_o(rv1),
    .ready_o(rdy1), .err_o(er1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] base_of(int i);
    return (i == 0) ? 32'h0 : BASE1;
  endfunction

  function automatic logic [31:0] errv_of(int i);
    return (i == 0) ? 32'h0 : ERR1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: flat word array, window test in 64-bit arithmetic.
  function automatic sb_t model_access(int i, logic [31:0] a,
                                       logic [3:0] s, logic [31:0] d);
    sb_t r;
    longint off;
    int w;
    off = longint'({32'h0, a}) - longint'({32'h0, base_of(i)});
    r.cyc = 0;
    if (off < 0 || off >= 4 * DW) begin
      r.data = errv_of(i);
      r.err = 1'b1;
    end else begin
      w = int'(off / 4);
      r.data = mm[i][w];
      r.err = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mm[i][w][8*b +: 8] = d[8*b +: 8];
      end
    end
    return r;
  endfunction

  // Raise all ports in m together from idle; service order is
  // upward from the model rr pointer, one access per 1+waits cycles.
  task automatic batch(int i, logic [NP-1:0] m, logic [32*NP-1:0] a,
                       logic [4*NP-1:0] s, logic [32*NP-1:0] d);
    int t, k, last, lat, guard, pp;
    sb_t e;
    logic [NP-1:0] pend, r;
    @(negedge clk);
    t = cyc;
    k = 0;
    last = 0;
    lat = 1 + ws_of(i);
    for (int j = 0; j < NP; j++) begin
      pp = (rr_m[i] + j) % NP;
      if (m[pp]) begin
        e = model_access(i, a[32*pp +: 32], s[4*pp +: 4], d[32*pp +: 32]);
        k++;
        e.cyc = t + k * lat;
        q[i*NP+pp].push_back(e);
        last = pp;
      end
    end
    if (k > 0) rr_m[i] = (last + 1) % NP;
    ad[i] = a;
    st[i] = s;
    wv[i] = d;
    en[i] = m;
    pend = m;
    guard = 0;
    while (pend != 0 && guard < 64) begin
      @(negedge clk);
      guard++;
      r = (i == 0) ? rdy0 : rdy1;
      for (int p = 0; p < NP; p++) begin
        if (pend[p] && r[p]) begin
          pend[p] = 1'b0;
          en[i][p] = 1'b0;
        end
      end
    end
    if (pend != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL batch_timeout inst%0d: pending %b expected 00", i, pend);
      en[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m[0] = 0;
    rr_m[1] = 0;
  endtask

  function automatic logic [31:0] rand_addr(int i);
    logic [31:0] w;
    logic [31:0] lo;
    w = 32'($urandom_range(0, 15));
    lo = 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) begin
      if (i == 0) return 32'h1000 + w * 4;
      if ($urandom_range(0, 1) == 0) return BASE1 - 32'd4 - w * 4;
      return BASE1 + 32'h1000 + w * 4;
    end
    return base_of(i) + w * 4 + lo;
  endfunction

  always @(negedge clk) begin : mon
    logic [NP-1:0] r, ee;
    logic [32*NP-1:0] vv;
    sb_t e;
    int k;
    for (int i = 0; i < 2; i++) begin
      r = (i == 0) ? rdy0 : rdy1;
      ee = (i == 0) ? er0 : er1;
      vv = (i == 0) ? rv0 : rv1;
      for (int p = 0; p < NP; p++) begin
        k = i * NP + p;
        if (r[p]) begin
          if (q[k].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_ready inst%0d port%0d: got 1 expected 0",
                     i, p);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("rvalue inst%0d port%0d", i, p),
                vv[32*p +: 32], e.data);
            chk($sformatf("err inst%0d port%0d", i, p),
                {31'b0, ee[p]}, {31'b0, e.err});
            chk($sformatf("ready_cycle inst%0d port%0d", i, p),
                32'(cyc), 32'(e.cyc));
          end
        end else begin
          chk($sformatf("idle_rvalue inst%0d port%0d", i, p),
              vv[32*p +: 32], 32'h0);
          chk($sformatf("idle_err inst%0d port%0d", i, p),
              {31'b0, ee[p]}, 32'h0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    logic [NP-1:0] m;
    logic [32*NP-1:0] a, d;
    logic [4*NP-1:0] s;
    for (int x = 0; x < 2; x++) begin
      en[x] = '0;
      st[x] = '0;
      ad[x] = '0;
      wv[x] = '0;
      rr_m[x] = 0;
      for (int w = 0; w < DW; w++) mm[x][w] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready0", 32'(rdy0), 32'h0);
    chk("reset_ready1", 32'(rdy1), 32'h0);
    chk("reset_err0", 32'(er0), 32'h0);
    chk("reset_err1", 32'(er1), 32'h0);
    chk("reset_rvalue0", rv0[31:0], 32'h0);
    chk("reset_rvalue1", rv1[63:32], 32'h0);
    rst = 1'b0;

    batch(0, 2'b01, {32'h0, 32'h10}, {4'h0, 4'hF}, {32'h0, 32'hDEADBEEF});
    batch(0, 2'b01, {32'h0, 32'h10}, '0, '0);
    batch(0, 2'b01, {32'h0, 32'h20}, {4'h0, 4'hF}, {32'h0, 32'h11223344});
    batch(0, 2'b01, {32'h0, 32'h20}, {4'h0, 4'b0101}, {32'h0, 32'hAABBCCDD});
    batch(0, 2'b01, {32'h0, 32'h23}, '0, '0);

    do_reset();
    batch(0, 2'b11, {32'h10, 32'h20}, '0, '0);
    batch(0, 2'b01, {32'h0, 32'h10}, '0, '0);
    batch(0, 2'b11, {32'h20, 32'h10}, '0, '0);
    batch(0, 2'b11, {32'h30, 32'h30}, {4'h0, 4'hF}, {32'h0, 32'h55667788});
    batch(0, 2'b10, {32'h30, 32'h0}, '0, '0);
    batch(0, 2'b01, {32'h0, 32'h1000}, {4'h0, 4'hF}, {32'h0, 32'h1});

    batch(1, 2'b01, {32'h0, BASE1}, {4'h0, 4'hF}, {32'h0, 32'h12345678});
    batch(1, 2'b01, {32'h0, BASE1 + 32'h1000}, {4'h0, 4'hF},
          {32'h0, 32'hCAFEF00D});
    batch(1, 2'b01, {32'h0, BASE1}, '0, '0);
    batch(1, 2'b10, {32'h7FFF_FFFC, 32'h0}, '0, '0);
    batch(1, 2'b11, {BASE1 + 32'h4, BASE1}, {4'hF, 4'h0},
          {32'h0BAD_F00D, 32'h0});

    // Reset lands on the access edge of a 3-wait write.
    @(negedge clk);
    ad[1] = {32'h0, BASE1};
    st[1] = {4'h0, 4'hF};
    wv[1] = {32'h0, 32'hFFFF_FFFF};
    en[1] = 2'b01;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en[1] = '0;
    rr_m[0] = 0;
    rr_m[1] = 0;
    repeat (3) @(negedge clk);
    batch(1, 2'b01, {32'h0, BASE1}, '0, '0);

    for (int n = 0; n < 80; n++) begin
      i = n % 2;
      m = NP'($urandom_range(1, 3));
      for (int p = 0; p < NP; p++) begin
        a[32*p +: 32] = rand_addr(i);
        s[4*p +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        d[32*p +: 32] = $urandom;
      end
      batch(i, m, a, s, d);
    end

    repeat (4) @(negedge clk);
    for (int k = 0; k < 2 * NP; k++) begin
      chk($sformatf("leftover_expected q%0d", k), 32'(q[k].size()), 32'h0);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
